// File: rtl/heap_command_sequencer_pkg.sv
// Shared definitions for the heap command sequencer: action codes,
// the illegal-action error code and the sequencer FSM states.
package heap_command_sequencer_pkg;

   localparam logic [7:0] ACTION_RESET = 8'd1;
   localparam logic [7:0] ACTION_WRITE = 8'd2;
   localparam logic [7:0] ACTION_DOWN  = 8'd11;
   localparam logic [7:0] ACTION_AND   = 8'd30;
   localparam logic [7:0] ACTION_MAX   = 8'd30;

   localparam logic [31:0] ERR_ILLEGAL_ACTION = 32'd10000280;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      RESPOND
   } seqStateT;

   // Action 0 is unused and anything above ACTION_MAX is unknown to the heap.
   function automatic logic isLegalAction(input logic [7:0] action);
      return (action != 8'd0) && (action <= ACTION_MAX);
   endfunction

endpackage

// File: rtl/heap_request_fifo.sv
// Synchronous request FIFO with full/empty flags. A push while full and a
// pop while empty are ignored; pointers wrap naturally at DEPTH (power of 2).
module heap_request_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]    storage [DEPTH];
   logic [PTR_BITS-1:0] writePtr;
   logic [PTR_BITS-1:0] readPtr;
   logic [PTR_BITS:0]   count;
   logic                doPush;
   logic                doPop;

   assign full    = (count == (PTR_BITS+1)'(DEPTH));
   assign empty   = (count == '0);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = storage[readPtr];

   // Pointer and occupancy bookkeeping; reset empties the buffer.
   always_ff @(posedge clock) begin
      if (!reset) begin
         writePtr <= '0;
         readPtr  <= '0;
         count    <= '0;
      end else begin
         if (doPush) writePtr <= writePtr + 1'b1;
         if (doPop)  readPtr  <= readPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; only slots behind the pointers are read.
   always_ff @(posedge clock) begin
      if (doPush) storage[writePtr] <= pushData;
   end

endmodule

// File: rtl/heap_command_sequencer.sv
// Buffers heap requests, replays each one onto the heap memory interface
// with a single heap_clock toggle, and returns the heap's answer in order.
module heap_command_sequencer
   import heap_command_sequencer_pkg::*;
#(
   parameter int ADDRESS_BITS = 2,
   parameter int INDEX_BITS   = 1,
   parameter int DATA_BITS    = 12,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [7:0]              req_action,
   input  logic [ADDRESS_BITS-1:0] req_array,
   input  logic [INDEX_BITS-1:0]   req_index,
   input  logic [DATA_BITS-1:0]    req_in,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_BITS-1:0]    rsp_out,
   output logic [31:0]             rsp_error,
   output logic                    heap_clock,
   output logic [7:0]              heap_action,
   output logic [ADDRESS_BITS-1:0] heap_array,
   output logic [INDEX_BITS-1:0]   heap_index,
   output logic [DATA_BITS-1:0]    heap_in,
   input  logic [DATA_BITS-1:0]    heap_out,
   input  logic [31:0]             heap_error,
   output logic                    busy,
   output logic [31:0]             ops_issued,
   output logic [31:0]             ops_rejected
);

   localparam int REQ_BITS = 8 + ADDRESS_BITS + INDEX_BITS + DATA_BITS;

   seqStateT                state;
   seqStateT                stateNext;
   logic [REQ_BITS-1:0]     pushWord;
   logic [REQ_BITS-1:0]     headWord;
   logic [7:0]              headAction;
   logic [ADDRESS_BITS-1:0] headArray;
   logic [INDEX_BITS-1:0]   headIndex;
   logic [DATA_BITS-1:0]    headIn;
   logic                    headLegal;
   logic                    fifoPush;
   logic                    fifoPop;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic                    readyEnable;
   // The heap clock must never move because of reset, so it carries only a
   // power-on value instead of a reset value.
   logic                    heapClockLevel = 1'b0;

   assign pushWord  = {req_action, req_array, req_index, req_in};
   assign {headAction, headArray, headIndex, headIn} = headWord;
   assign headLegal = isLegalAction(headAction);

   assign req_ready  = readyEnable && !fifoFull;
   assign fifoPush   = req_valid && req_ready;
   assign rsp_valid  = (state == RESPOND);
   assign busy       = (state != IDLE) || !fifoEmpty;
   assign heap_clock = heapClockLevel;

   heap_request_fifo #(
      .WIDTH (REQ_BITS),
      .DEPTH (FIFO_DEPTH)
   ) requestFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifoPush),
      .pushData (pushWord),
      .pop      (fifoPop),
      .popData  (headWord),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // State register; readyEnable holds req_ready low until the first edge out of reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         readyEnable <= 1'b0;
      end else begin
         state       <= stateNext;
         readyEnable <= 1'b1;
      end
   end

   // Next-state selection; SETUP always consumes the FIFO head.
   always_comb begin
      stateNext = state;
      fifoPop   = 1'b0;
      case (state)
         IDLE:    if (!fifoEmpty) stateNext = SETUP;
         SETUP: begin
            fifoPop   = 1'b1;
            stateNext = headLegal ? STROBE : RESPOND;
         end
         STROBE:  stateNext = RESPOND;
         RESPOND: if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Heap command registers, response capture and operation counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         heap_action  <= '0;
         heap_array   <= '0;
         heap_index   <= '0;
         heap_in      <= '0;
         rsp_out      <= '0;
         rsp_error    <= '0;
         ops_issued   <= '0;
         ops_rejected <= '0;
      end else begin
         if (state == SETUP) begin
            heap_action <= headAction;
            heap_array  <= headArray;
            heap_index  <= headIndex;
            heap_in     <= headIn;
            if (!headLegal) begin
               rsp_out      <= '0;
               rsp_error    <= ERR_ILLEGAL_ACTION;
               ops_rejected <= ops_rejected + 32'd1;
            end
         end
         if (state == STROBE) begin
            rsp_out    <= heap_out;
            rsp_error  <= heap_error;
            ops_issued <= ops_issued + 32'd1;
         end
      end
   end

   // One heap strobe per legal command, on the edge that enters STROBE.
   always_ff @(posedge clock) begin
      if (reset && (state == SETUP) && headLegal) heapClockLevel <= !heapClockLevel;
   end

endmodule

// File: tb/tb_heap_command_sequencer.sv
// Self-checking bench for heap_command_sequencer: directed scenarios plus
// randomized traffic, checked against a request-order reference model.
module tb_heap_command_sequencer;

   localparam int AB = 2;
   localparam int IB = 1;
   localparam int DB = 12;
   localparam int FD = 4;

   typedef struct {
      logic [DB-1:0] out;
      logic [31:0]   err;
      bit            legal;
   } expT;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [7:0]    req_action = '0;
   logic [AB-1:0] req_array = '0;
   logic [IB-1:0] req_index = '0;
   logic [DB-1:0] req_in = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DB-1:0] rsp_out;
   logic [31:0]   rsp_error;
   logic          heap_clock;
   logic [7:0]    heap_action;
   logic [AB-1:0] heap_array;
   logic [IB-1:0] heap_index;
   logic [DB-1:0] heap_in;
   logic [DB-1:0] heap_out;
   logic [31:0]   heap_error;
   logic          busy;
   logic [31:0]   ops_issued;
   logic [31:0]   ops_rejected;

   int  checks = 0;
   int  errors = 0;
   int  expIssued = 0;
   int  expRejected = 0;
   int  expToggles = 0;
   int  toggles = 0;
   logic lastHeapClock = 1'b0;
   expT expQ[$];

   int  stalls;
   int  lat;
   int  burst;

   heap_command_sequencer #(
      .ADDRESS_BITS (AB),
      .INDEX_BITS   (IB),
      .DATA_BITS    (DB),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_action   (req_action),
      .req_array    (req_array),
      .req_index    (req_index),
      .req_in       (req_in),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_out      (rsp_out),
      .rsp_error    (rsp_error),
      .heap_clock   (heap_clock),
      .heap_action  (heap_action),
      .heap_array   (heap_array),
      .heap_index   (heap_index),
      .heap_in      (heap_in),
      .heap_out     (heap_out),
      .heap_error   (heap_error),
      .busy         (busy),
      .ops_issued   (ops_issued),
      .ops_rejected (ops_rejected)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Stand-in heap memory: answer is a fixed mix of the command fields.
   function automatic logic [DB-1:0] heapModel(input logic [7:0] act, input logic [AB-1:0] arr,
                                               input logic [IB-1:0] idx, input logic [DB-1:0] din);
      logic [31:0] mix;
      mix = 32'(din) ^ (32'(act) * 32'd37) ^ (32'(arr) << 4) ^ (32'(idx) << 7);
      return mix[DB-1:0];
   endfunction

   // The heap reports an error code only for Down commands.
   function automatic logic [31:0] errModel(input logic [7:0] act);
      return (act == 8'd11) ? 32'd100000274 : 32'd0;
   endfunction

   assign heap_out   = heapModel(heap_action, heap_array, heap_index, heap_in);
   assign heap_error = errModel(heap_action);

   // Count every heap_clock transition as one strobe.
   always @(heap_clock) begin
      if (heap_clock !== lastHeapClock) begin
         toggles++;
         lastHeapClock = heap_clock;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offer one request at a falling edge once req_ready allows it, and log the expected response.
   task automatic applyStimulus(input logic [7:0] act, input logic [AB-1:0] arr, input logic [IB-1:0] idx,
                                input logic [DB-1:0] din, output int waited);
      expT item;
      waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (!req_ready) begin
         checkOutput("accept_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid  = 1'b1;
      req_action = act;
      req_array  = arr;
      req_index  = idx;
      req_in     = din;
      @(negedge clock);
      req_valid  = 1'b0;
      if (act >= 8'd1 && act <= 8'd30) begin
         item.out = heapModel(act, arr, idx, din);
         item.err = errModel(act);
         item.legal = 1'b1;
      end else begin
         item.out = '0;
         item.err = 32'd10000280;
         item.legal = 1'b0;
      end
      expQ.push_back(item);
   endtask

   // Wait for the next response, compare it with the oldest expected one, then accept it.
   task automatic collectResponse(input string tag);
      int  waitCycles;
      expT item;
      waitCycles = 0;
      while (!rsp_valid && waitCycles < 50) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
         end else begin
            item = expQ.pop_front();
            if (item.legal) begin
               expIssued++;
               expToggles++;
            end else begin
               expRejected++;
            end
            checkOutput({tag, "_out"}, 32'(rsp_out), 32'(item.out));
            checkOutput({tag, "_err"}, rsp_error, item.err);
            checkOutput({tag, "_issued"}, ops_issued, 32'(expIssued));
            checkOutput({tag, "_rejected"}, ops_rejected, 32'(expRejected));
            checkOutput({tag, "_strobes"}, 32'(toggles), 32'(expToggles));
         end
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rsp_out", 32'(rsp_out), 32'd0);
      checkOutput("rst_rsp_error", rsp_error, 32'd0);
      checkOutput("rst_heap_action", 32'(heap_action), 32'd0);
      checkOutput("rst_heap_in", 32'(heap_in), 32'd0);
      checkOutput("rst_ops_issued", ops_issued, 32'd0);
      checkOutput("rst_ops_rejected", ops_rejected, 32'd0);
      checkOutput("rst_heap_clock", 32'(heap_clock), 32'd0);
      reset = 1'b1;
      checkOutput("ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clock);
      checkOutput("ready_after_edge", 32'(req_ready), 32'd1);

      // Single legal Write: three-edge latency, one strobe
      rsp_ready = 1'b1;
      applyStimulus(8'd2, 2'd1, 1'd0, 12'h0AB, stalls);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checkOutput("write_latency", 32'(lat), 32'd3);
      collectResponse("write");
      checkOutput("write_rsp_dropped", 32'(rsp_valid), 32'd0);

      // Illegal action 31: two-edge latency, no strobe
      applyStimulus(8'd31, 2'd2, 1'd1, DB'($urandom()), stalls);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checkOutput("illegal_latency", 32'(lat), 32'd2);
      collectResponse("illegal");

      // Five back-to-back legal requests while responses are held off
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'($urandom_range(1, 30)), AB'($urandom()), IB'($urandom()), DB'($urandom()), stalls);
         checkOutput($sformatf("burst_stall_%0d", i), 32'(stalls), 32'd0);
      end
      checkOutput("burst_full", 32'(req_ready), 32'd0);

      // Hold rsp_ready low in RESPOND: response must stay put, no new strobe
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
         checkOutput($sformatf("hold_out_%0d", i), 32'(rsp_out), 32'(expQ[0].out));
         checkOutput($sformatf("hold_err_%0d", i), rsp_error, expQ[0].err);
         checkOutput($sformatf("hold_strobes_%0d", i), 32'(toggles), 32'(expToggles + 1));
         @(negedge clock);
      end
      for (int i = 0; i < 5; i++) collectResponse($sformatf("burst_rsp_%0d", i));

      // Reset during STROBE with a second request still buffered
      applyStimulus(8'd5, 2'd3, 1'd1, 12'h123, stalls);
      applyStimulus(8'd6, 2'd0, 1'd0, 12'h456, stalls);
      @(negedge clock);
      checkOutput("mid_strobe_seen", 32'(toggles), 32'(expToggles + 1));
      expToggles++;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_issued", ops_issued, 32'd0);
      checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("mid_rst_strobes", 32'(toggles), 32'(expToggles));
      repeat (2) @(negedge clock);
      reset = 1'b1;
      expQ.delete();
      expIssued = 0;
      expRejected = 0;
      repeat (6) @(negedge clock);
      checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_strobes", 32'(toggles), 32'(expToggles));
      checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Down command: heap error code passes straight through
      applyStimulus(8'd11, AB'($urandom()), IB'($urandom()), DB'($urandom()), stalls);
      collectResponse("down");

      // Randomized bursts mixing legal and illegal actions
      for (int r = 0; r < 8; r++) begin
         burst = $urandom_range(1, 4);
         for (int i = 0; i < burst; i++) begin
            applyStimulus(8'($urandom_range(0, 40)), AB'($urandom()), IB'($urandom()), DB'($urandom()), stalls);
         end
         for (int i = 0; i < burst; i++) collectResponse($sformatf("rand_%0d_%0d", r, i));
      end
      repeat (2) @(negedge clock);
      checkOutput("final_busy", 32'(busy), 32'd0);
      checkOutput("final_queue", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
